// File: rtl/mem_buffer_reducer_if.sv
// Memory line-read bus between the buffer reducer (master) and a memory port (slave).
// Request: a line address transfers on a cycle where mem_req_valid & mem_req_ready are both high;
// valid and line must then hold until that cycle. Response: one mem_resp_valid pulse per accepted request.
interface mem_buffer_reducer_if #(
  parameter int LINE_ADDR_WIDTH = 28,
  parameter int LINE_WIDTH      = 128
);
  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic [LINE_ADDR_WIDTH-1:0] mem_req_line;
  logic                       mem_resp_valid;
  logic [LINE_WIDTH-1:0]      mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_line,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_line,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/mem_buffer_reducer.sv
// Walks COUNT words from a byte address, one memory line at a time, and reduces them
// with SUM / XOR / unsigned MAX / unsigned MIN into an ACC_WIDTH result.
module mem_buffer_reducer #(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int ACC_WIDTH      = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [ACC_WIDTH-1:0]   result,
  output logic                   overflow,
  mem_buffer_reducer_if.master   mem,
  output logic [2:0]             state_dbg
);
  localparam int LINE_WIDTH      = WORDS_PER_LINE * WORD_WIDTH;
  localparam int LINE_SHIFT      = $clog2(LINE_WIDTH / 8);
  localparam int LINE_ADDR_WIDTH = ADDR_WIDTH - LINE_SHIFT;
  localparam int WB              = $clog2(WORD_WIDTH / 8);
  localparam int IW              = $clog2(WORDS_PER_LINE);

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_XOR = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ACC   = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t                     state;
  logic [1:0]                 mode_q;
  logic [COUNT_WIDTH-1:0]     rem;
  logic [LINE_ADDR_WIDTH-1:0] line_q;
  logic [IW-1:0]              widx;
  logic [LINE_WIDTH-1:0]      line_buf;
  logic [ACC_WIDTH-1:0]       acc;
  logic                       carry_q;
  logic                       req_valid;

  logic [WORD_WIDTH-1:0]      cur_word;
  logic [ACC_WIDTH-1:0]       word_ext;
  logic [ACC_WIDTH:0]         sum_ext;
  logic [ACC_WIDTH-1:0]       acc_next;
  logic                       carry_next;
  logic [ACC_WIDTH-1:0]       identity;
  logic                       unused_bits;

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_line  = line_q;
  assign state_dbg         = state;
  // Sub-word byte offset bits cannot select anything; words are always whole.
  assign unused_bits       = ^base_addr[WB-1:0];

  assign identity = (mode == 2'd3) ? ACC_WIDTH'({WORD_WIDTH{1'b1}}) : '0;

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (widx == IW'(i)) cur_word = line_buf[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_comb begin
    word_ext   = ACC_WIDTH'(cur_word);
    sum_ext    = {1'b0, acc} + {1'b0, word_ext};
    acc_next   = acc;
    carry_next = carry_q;
    case (mode_q)
      MODE_SUM: begin
        acc_next   = sum_ext[ACC_WIDTH-1:0];
        carry_next = carry_q | sum_ext[ACC_WIDTH];
      end
      MODE_XOR: acc_next = acc ^ word_ext;
      MODE_MAX: if (word_ext > acc) acc_next = word_ext;
      default:  if (word_ext < acc) acc_next = word_ext;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      rem       <= '0;
      line_q    <= '0;
      widx      <= '0;
      line_buf  <= '0;
      acc       <= '0;
      carry_q   <= 1'b0;
      req_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            rem     <= count;
            line_q  <= base_addr[ADDR_WIDTH-1:LINE_SHIFT];
            widx    <= base_addr[LINE_SHIFT-1:WB];
            acc     <= identity;
            carry_q <= 1'b0;
            busy    <= 1'b1;
            if (count == '0) begin
              state <= S_DONE;
            end else begin
              state     <= S_REQ;
              req_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // A request already accepted must have its response drained even when aborted.
          if (mem.mem_req_ready) begin
            req_valid <= 1'b0;
            state     <= abort ? S_DRAIN : S_WAIT;
          end else if (abort) begin
            req_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (mem.mem_resp_valid) begin
            if (abort) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              line_buf <= mem.mem_resp_data;
              state    <= S_ACC;
            end
          end else if (abort) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem.mem_resp_valid) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_ACC: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            acc     <= acc_next;
            carry_q <= carry_next;
            rem     <= rem - COUNT_WIDTH'(1);
            if (rem == COUNT_WIDTH'(1)) begin
              state <= S_DONE;
            end else if (widx == IW'(WORDS_PER_LINE - 1)) begin
              widx      <= '0;
              line_q    <= line_q + LINE_ADDR_WIDTH'(1);
              req_valid <= 1'b1;
              state     <= S_REQ;
            end else begin
              widx <= widx + IW'(1);
            end
          end
        end
        S_DONE: begin
          done     <= 1'b1;
          result   <= acc;
          overflow <= carry_q;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          req_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_buffer_reducer.sv
// Directed bench for mem_buffer_reducer: a 64-bit accumulator instance on a configurable
// stall/latency memory model, plus a 32-bit accumulator instance for adder overflow.
module tb_mem_buffer_reducer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- instance A: ACC_WIDTH 64 ----------------
  logic        a_start = 1'b0, a_abort = 1'b0;
  logic [1:0]  a_mode  = 2'd0;
  logic [31:0] a_base  = '0;
  logic [15:0] a_count = '0;
  logic        a_busy, a_done, a_overflow;
  logic [63:0] a_result;
  logic [2:0]  a_state;
  mem_buffer_reducer_if #(.LINE_ADDR_WIDTH(28), .LINE_WIDTH(128)) a_if ();

  mem_buffer_reducer #(.ACC_WIDTH(64)) dut_a (
    .clock(clock), .reset(reset), .start(a_start), .mode(a_mode), .base_addr(a_base),
    .count(a_count), .abort(a_abort), .busy(a_busy), .done(a_done), .result(a_result),
    .overflow(a_overflow), .mem(a_if.master), .state_dbg(a_state)
  );

  // ---------------- instance B: ACC_WIDTH 32 ----------------
  logic         b_start = 1'b0, b_abort = 1'b0;
  logic [1:0]   b_mode  = 2'd0;
  logic [31:0]  b_base  = '0;
  logic [15:0]  b_count = '0;
  logic         b_busy, b_done, b_overflow;
  logic [31:0]  b_result;
  logic [2:0]   b_state;
  logic [127:0] b_line = '0;
  mem_buffer_reducer_if #(.LINE_ADDR_WIDTH(28), .LINE_WIDTH(128)) b_if ();

  mem_buffer_reducer #(.ACC_WIDTH(32)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .mode(b_mode), .base_addr(b_base),
    .count(b_count), .abort(b_abort), .busy(b_busy), .done(b_done), .result(b_result),
    .overflow(b_overflow), .mem(b_if.master), .state_dbg(b_state)
  );

  assign b_if.mem_req_ready = 1'b1;
  always @(posedge clock) begin
    b_if.mem_resp_valid <= b_if.mem_req_valid & b_if.mem_req_ready;
    b_if.mem_resp_data  <= b_line;
  end

  // ---------------- memory model for A ----------------
  // Word at byte address 0x1800 + 4*i holds i.
  function automatic logic [127:0] line_data(input logic [27:0] line);
    logic [127:0] d;
    for (int j = 0; j < 4; j++) d[j*32 +: 32] = 32'({line, 2'b00}) + 32'(j) - 32'h600;
    return d;
  endfunction

  int          a_lat = 1, a_stall = 0;
  int          a_stall_cnt = 0, a_pend_cnt = 0;
  logic        a_pend = 1'b0;
  logic [27:0] a_pend_line = '0;
  logic        a_wait_seen = 1'b0;
  logic [27:0] a_wait_line = '0;
  int          a_unstable_cnt = 0, a_valid_cnt = 0, a_done_cnt = 0;
  logic [27:0] req_log[$];
  logic [27:0] exp_q[$];

  always @(posedge clock) begin
    a_if.mem_resp_valid <= 1'b0;
    if (a_if.mem_req_valid === 1'b1) a_valid_cnt <= a_valid_cnt + 1;
    if (a_done === 1'b1) a_done_cnt <= a_done_cnt + 1;
    if (a_pend) begin
      if (a_pend_cnt <= 1) begin
        a_if.mem_resp_valid <= 1'b1;
        a_if.mem_resp_data  <= line_data(a_pend_line);
        a_pend <= 1'b0;
      end else a_pend_cnt <= a_pend_cnt - 1;
    end
    if (a_if.mem_req_valid === 1'b1 && a_if.mem_req_ready === 1'b1) begin
      req_log.push_back(a_if.mem_req_line);
      if (a_lat <= 1) begin
        a_if.mem_resp_valid <= 1'b1;
        a_if.mem_resp_data  <= line_data(a_if.mem_req_line);
      end else begin
        a_pend      <= 1'b1;
        a_pend_cnt  <= a_lat - 1;
        a_pend_line <= a_if.mem_req_line;
      end
      a_if.mem_req_ready <= (a_stall == 0);
      a_stall_cnt <= 0;
      a_wait_seen <= 1'b0;
    end else if (a_if.mem_req_valid === 1'b1) begin
      if (a_wait_seen && a_if.mem_req_line !== a_wait_line) a_unstable_cnt <= a_unstable_cnt + 1;
      a_wait_seen <= 1'b1;
      a_wait_line <= a_if.mem_req_line;
      if (a_stall_cnt + 1 >= a_stall) a_if.mem_req_ready <= 1'b1;
      a_stall_cnt <= a_stall_cnt + 1;
    end else begin
      a_if.mem_req_ready <= (a_stall == 0);
      a_stall_cnt <= 0;
      a_wait_seen <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_a(input logic [1:0] m, input logic [31:0] addr, input logic [15:0] cnt,
                       output logic got);
    a_mode = m; a_base = addr; a_count = cnt; a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (a_done === 1'b1) begin got = 1'b1; break; end
      @(negedge clock);
    end
  endtask

  task automatic run_b(input logic [15:0] cnt, output logic got);
    b_mode = 2'd0; b_base = '0; b_count = cnt; b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (b_done === 1'b1) begin got = 1'b1; break; end
      @(negedge clock);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", a_busy); else n_pass++;
    n_checks++; if (a_done !== 1'b0) $display("FAIL reset_done got %b exp 0", a_done); else n_pass++;
    n_checks++; if (a_result !== 64'd0) $display("FAIL reset_result got %h exp 0", a_result); else n_pass++;
    n_checks++; if (a_overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", a_overflow); else n_pass++;
    n_checks++; if (a_if.mem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", a_if.mem_req_valid); else n_pass++;
    n_checks++; if (a_state !== 3'd0) $display("FAIL reset_state got %0d exp 0", a_state); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_sum_aligned(input string tag);
    logic got;
    req_log.delete(); exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(28'h180 + 28'(i));
    run_a(2'd0, 32'h1800, 16'd128, got);
    n_checks++; if (got !== 1'b1) $display("FAIL %s_done got %b exp 1", tag, got); else n_pass++;
    n_checks++; if (a_result !== 64'd8128) $display("FAIL %s_result got %0d exp 8128", tag, a_result); else n_pass++;
    n_checks++; if (a_overflow !== 1'b0) $display("FAIL %s_overflow got %b exp 0", tag, a_overflow); else n_pass++;
    n_checks++; if (req_log.size() !== exp_q.size()) $display("FAIL %s_nreq got %0d exp %0d", tag, req_log.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < req_log.size(); i++) begin
      n_checks++; if (req_log[i] !== exp_q[i]) $display("FAIL %s_line%0d got %h exp %h", tag, i, req_log[i], exp_q[i]); else n_pass++;
    end
    @(negedge clock);
  endtask

  task automatic test_unaligned_modes;
    logic got;
    logic [63:0] exp_r[4];
    exp_r[0] = 64'd15; exp_r[1] = 64'd1; exp_r[2] = 64'd5; exp_r[3] = 64'd1;
    for (int m = 0; m < 4; m++) begin
      req_log.delete(); exp_q.delete();
      exp_q.push_back(28'h180); exp_q.push_back(28'h181);
      run_a(2'(m), 32'h1804, 16'd5, got);
      n_checks++; if (got !== 1'b1) $display("FAIL unal_m%0d_done got %b exp 1", m, got); else n_pass++;
      n_checks++; if (a_result !== exp_r[m]) $display("FAIL unal_m%0d_result got %0d exp %0d", m, a_result, exp_r[m]); else n_pass++;
      n_checks++; if (req_log.size() !== exp_q.size()) $display("FAIL unal_m%0d_nreq got %0d exp 2", m, req_log.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < req_log.size(); i++) begin
        n_checks++; if (req_log[i] !== exp_q[i]) $display("FAIL unal_m%0d_line%0d got %h exp %h", m, i, req_log[i], exp_q[i]); else n_pass++;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_count_zero;
    int v0;
    v0 = a_valid_cnt;
    a_mode = 2'd3; a_base = 32'h1800; a_count = 16'd0; a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    n_checks++; if (a_done !== 1'b0) $display("FAIL cz_done_early got %b exp 0", a_done); else n_pass++;
    n_checks++; if (a_busy !== 1'b1) $display("FAIL cz_busy got %b exp 1", a_busy); else n_pass++;
    @(negedge clock);
    n_checks++; if (a_done !== 1'b1) $display("FAIL cz_done got %b exp 1", a_done); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL cz_busy_end got %b exp 0", a_busy); else n_pass++;
    n_checks++; if (a_result !== 64'h0000_0000_FFFF_FFFF) $display("FAIL cz_result got %h exp ffffffff", a_result); else n_pass++;
    @(negedge clock);
    n_checks++; if (a_done !== 1'b0) $display("FAIL cz_done_pulse got %b exp 0", a_done); else n_pass++;
    n_checks++; if (a_valid_cnt !== v0) $display("FAIL cz_no_req got %0d exp %0d", a_valid_cnt, v0); else n_pass++;
  endtask

  task automatic test_overflow;
    logic got;
    b_line = {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF};
    run_b(16'd2, got);
    n_checks++; if (got !== 1'b1) $display("FAIL ovf1_done got %b exp 1", got); else n_pass++;
    n_checks++; if (b_result !== 32'd1) $display("FAIL ovf1_result got %0d exp 1", b_result); else n_pass++;
    n_checks++; if (b_overflow !== 1'b1) $display("FAIL ovf1_overflow got %b exp 1", b_overflow); else n_pass++;
    @(negedge clock);
    b_line = {32'd0, 32'd0, 32'd1, 32'd1};
    run_b(16'd2, got);
    n_checks++; if (got !== 1'b1) $display("FAIL ovf2_done got %b exp 1", got); else n_pass++;
    n_checks++; if (b_result !== 32'd2) $display("FAIL ovf2_result got %0d exp 2", b_result); else n_pass++;
    n_checks++; if (b_overflow !== 1'b0) $display("FAIL ovf2_overflow got %b exp 0", b_overflow); else n_pass++;
    @(negedge clock);
    n_checks++; if (b_state !== 3'd0) $display("FAIL ovf2_state got %0d exp 0", b_state); else n_pass++;
  endtask

  task automatic test_stall_latency;
    int u0;
    u0 = a_unstable_cnt;
    a_stall = 10; a_lat = 7;
    repeat (2) @(negedge clock);
    test_sum_aligned("stall");
    n_checks++; if (a_unstable_cnt !== u0) $display("FAIL stall_line_stable got %0d changes exp 0", a_unstable_cnt - u0); else n_pass++;
    a_stall = 0; a_lat = 1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_abort_reset;
    int d0;
    logic got;
    a_lat = 7;
    d0 = a_done_cnt;
    req_log.delete();
    a_mode = 2'd0; a_base = 32'h1800; a_count = 16'd16; a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    for (int i = 0; i < 50 && req_log.size() == 0; i++) @(negedge clock);
    @(negedge clock);
    a_abort = 1'b1;
    @(negedge clock);
    a_abort = 1'b0;
    n_checks++; if (a_busy !== 1'b1) $display("FAIL abort_draining_busy got %b exp 1", a_busy); else n_pass++;
    for (int i = 0; i < 30 && a_busy === 1'b1; i++) @(negedge clock);
    n_checks++; if (a_busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", a_busy); else n_pass++;
    n_checks++; if (a_done_cnt !== d0) $display("FAIL abort_no_done got %0d exp %0d", a_done_cnt, d0); else n_pass++;
    n_checks++; if (a_result !== 64'd8128) $display("FAIL abort_result_kept got %0d exp 8128", a_result); else n_pass++;
    n_checks++; if (req_log.size() !== 1) $display("FAIL abort_nreq got %0d exp 1", req_log.size()); else n_pass++;

    req_log.delete();
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    for (int i = 0; i < 50 && req_log.size() == 0; i++) @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (a_busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", a_busy); else n_pass++;
    n_checks++; if (a_result !== 64'd0) $display("FAIL rst_mid_result got %0d exp 0", a_result); else n_pass++;
    reset = 1'b0;
    repeat (12) @(negedge clock);
    n_checks++; if (a_state !== 3'd0) $display("FAIL stale_state got %0d exp 0", a_state); else n_pass++;
    n_checks++; if (a_done_cnt !== d0) $display("FAIL stale_no_done got %0d exp %0d", a_done_cnt, d0); else n_pass++;
    n_checks++; if (a_if.mem_req_valid !== 1'b0) $display("FAIL stale_req_valid got %b exp 0", a_if.mem_req_valid); else n_pass++;

    a_lat = 1;
    req_log.delete();
    run_a(2'd0, 32'h1804, 16'd5, got);
    n_checks++; if (got !== 1'b1) $display("FAIL after_rst_done got %b exp 1", got); else n_pass++;
    n_checks++; if (a_result !== 64'd15) $display("FAIL after_rst_result got %0d exp 15", a_result); else n_pass++;
    n_checks++; if (req_log.size() !== 2) $display("FAIL after_rst_nreq got %0d exp 2", req_log.size()); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sum_aligned("sum128");
    test_unaligned_modes();
    test_count_zero();
    test_overflow();
    test_stall_latency();
    test_abort_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
